// File: rtl/ysyx_24080006_axi_sram_if.sv
// AXI4 bus bundle shared by the SRAM slave and its masters.
// Single-beat subset: AR/R/AW/W/B with ids, lengths and strobes.
interface ysyx_24080006_axi;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [7:0]  arlen;
  logic [3:0]  arid;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [7:0]  awlen;
  logic [3:0]  awid;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arsize, arlen, arid, arvalid,
    output arready,
    output rdata, rresp, rid, rlast, rvalid,
    input  rready,
    input  awaddr, awsize, awlen, awid, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );

  modport master (
    output araddr, arsize, arlen, arid, arvalid,
    input  arready,
    input  rdata, rresp, rid, rlast, rvalid,
    output rready,
    output awaddr, awsize, awlen, awid, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );
endinterface

// File: rtl/ysyx_24080006_axi_sram.sv
// Single-outstanding AXI SRAM slave with programmable latency.
// Reads win over writes when both arrive in IDLE.
module ysyx_24080006_axi_sram #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          READ_LAT  = 1,
  parameter int          WRITE_LAT = 1
) (
  input logic             clock,
  input logic             reset,
  ysyx_24080006_axi.slave axi_s
);
  localparam int          IW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
  localparam logic [3:0]  RL   = 4'(READ_LAT);
  localparam logic [3:0]  WL   = 4'(WRITE_LAT);

  typedef enum logic [2:0] {
    IDLE, RD_LAT, RD_RESP,
    WR_COLLECT, WR_LAT, WR_RESP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [31:0] ar_addr_q, aw_addr_q, w_data_q;
  logic [7:0]  ar_len_q, aw_len_q;
  logic [3:0]  ar_id_q, aw_id_q, w_strb_q;
  logic        aw_got, w_got;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q, bresp_q;
  logic [31:0] mem [DEPTH];

  logic ar_hs, aw_hs, w_hs;
  logic rd_load, wr_commit;

  assign axi_s.arready = !reset && state == IDLE;
  assign axi_s.awready = !reset &&
    ((state == IDLE && !axi_s.arvalid) ||
     (state == WR_COLLECT && !aw_got));
  assign axi_s.wready = !reset &&
    ((state == IDLE && !axi_s.arvalid) ||
     (state == WR_COLLECT && !w_got));

  assign ar_hs = axi_s.arvalid && axi_s.arready;
  assign aw_hs = axi_s.awvalid && axi_s.awready;
  assign w_hs  = axi_s.wvalid && axi_s.wready;

  // Zero latency settings commit in the handshake cycle itself,
  // so the effective request mixes live and captured fields.
  logic [31:0] ra_eff, wa_eff, wd_eff;
  logic [7:0]  rl_eff, wl_eff;
  logic [3:0]  ws_eff;
  assign ra_eff = (state == IDLE) ? axi_s.araddr : ar_addr_q;
  assign rl_eff = (state == IDLE) ? axi_s.arlen : ar_len_q;
  assign wa_eff = aw_got ? aw_addr_q : axi_s.awaddr;
  assign wl_eff = aw_got ? aw_len_q : axi_s.awlen;
  assign wd_eff = w_got ? w_data_q : axi_s.wdata;
  assign ws_eff = w_got ? w_strb_q : axi_s.wstrb;

  logic [31:0]   rd_off, wr_off;
  logic          rd_ok, wr_ok;
  logic [IW-1:0] rd_idx, wr_idx;
  assign rd_off = ra_eff - BASE_ADDR;
  assign wr_off = wa_eff - BASE_ADDR;
  assign rd_ok  = ({1'b0, rd_off} < SPAN) && rl_eff == 8'd0;
  assign wr_ok  = ({1'b0, wr_off} < SPAN) && wl_eff == 8'd0;
  assign rd_idx = rd_off[IW+1:2];
  assign wr_idx = wr_off[IW+1:2];

  logic unused_ok;
  assign unused_ok = ^{rd_off, wr_off, axi_s.arsize,
                       axi_s.awsize, axi_s.wlast};

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (ar_hs) begin
          state_n = (RL == 4'd0) ? RD_RESP : RD_LAT;
          cnt_n   = RL;
        end else if (aw_hs && w_hs) begin
          state_n = (WL == 4'd0) ? WR_RESP : WR_LAT;
          cnt_n   = WL;
        end else if (aw_hs || w_hs) begin
          state_n = WR_COLLECT;
        end
      end
      RD_LAT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = RD_RESP;
      end
      RD_RESP: if (axi_s.rready) state_n = IDLE;
      WR_COLLECT: begin
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          state_n = (WL == 4'd0) ? WR_RESP : WR_LAT;
          cnt_n   = WL;
        end
      end
      WR_LAT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = WR_RESP;
      end
      WR_RESP: if (axi_s.bready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign rd_load   = state_n == RD_RESP && state != RD_RESP;
  assign wr_commit = state_n == WR_RESP && state != WR_RESP;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_id_q   <= '0;
      aw_addr_q <= '0;
      aw_len_q  <= '0;
      aw_id_q   <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      bresp_q   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      aw_got <= (state_n == IDLE) ? 1'b0 : (aw_got || aw_hs);
      w_got  <= (state_n == IDLE) ? 1'b0 : (w_got || w_hs);
      if (ar_hs) begin
        ar_addr_q <= axi_s.araddr;
        ar_len_q  <= axi_s.arlen;
        ar_id_q   <= axi_s.arid;
      end
      if (aw_hs) begin
        aw_addr_q <= axi_s.awaddr;
        aw_len_q  <= axi_s.awlen;
        aw_id_q   <= axi_s.awid;
      end
      if (w_hs) begin
        w_data_q <= axi_s.wdata;
        w_strb_q <= axi_s.wstrb;
      end
      if (rd_load) begin
        rdata_q <= rd_ok ? mem[rd_idx] : 32'h0;
        rresp_q <= rd_ok ? 2'b00 : 2'b10;
      end
      if (wr_commit) bresp_q <= wr_ok ? 2'b00 : 2'b10;
    end
  end

  // Memory has no reset so its contents survive a bus reset.
  always_ff @(posedge clock) begin
    if (wr_commit && wr_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (ws_eff[i]) mem[wr_idx][8*i +: 8] <= wd_eff[8*i +: 8];
      end
    end
  end

  assign axi_s.rvalid = state == RD_RESP;
  assign axi_s.rlast  = state == RD_RESP;
  assign axi_s.rdata  = rdata_q;
  assign axi_s.rresp  = rresp_q;
  assign axi_s.rid    = ar_id_q;
  assign axi_s.bvalid = state == WR_RESP;
  assign axi_s.bresp  = bresp_q;
  assign axi_s.bid    = aw_id_q;
endmodule

// File: tb/tb_ysyx_24080006_axi_sram.sv
// Directed bench for the AXI SRAM slave.
// READ_LAT = WRITE_LAT = 1, base 0x8000_0000, 4096 words.
module tb_ysyx_24080006_axi_sram;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ysyx_24080006_axi axi ();

  ysyx_24080006_axi_sram #(
    .DEPTH(4096),
    .BASE_ADDR(32'h8000_0000),
    .READ_LAT(1),
    .WRITE_LAT(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axi_s(axi)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_master();
    axi.araddr  = '0; axi.arsize = 3'd2; axi.arlen = '0;
    axi.arid    = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    axi.awaddr  = '0; axi.awsize = 3'd2; axi.awlen = '0;
    axi.awid    = '0; axi.awvalid = 1'b0;
    axi.wdata   = '0; axi.wstrb = '0; axi.wlast = 1'b0;
    axi.wvalid  = 1'b0; axi.bready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [7:0] len,
                          output logic [1:0] resp);
    logic aw_f, w_f, got;
    axi.awaddr = a; axi.awlen = len; axi.awid = 4'h3;
    axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wlast = 1'b1;
    axi.wvalid = 1'b1; axi.bready = 1'b1;
    resp = 2'bxx;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      aw_f = axi.awvalid && axi.awready;
      w_f  = axi.wvalid && axi.wready;
      if (axi.bvalid) begin
        resp = axi.bresp;
        got  = 1'b1;
      end
      tick();
      if (aw_f) axi.awvalid = 1'b0;
      if (w_f) axi.wvalid = 1'b0;
    end
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [7:0] len,
                         output logic [31:0] data,
                         output logic [1:0] resp);
    logic ar_f, got;
    axi.araddr = a; axi.arlen = len; axi.arid = 4'h5;
    axi.arvalid = 1'b1; axi.rready = 1'b1;
    data = 'x;
    resp = 2'bxx;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      ar_f = axi.arvalid && axi.arready;
      if (axi.rvalid) begin
        data = axi.rdata;
        resp = axi.rresp;
        got  = 1'b1;
      end
      tick();
      if (ar_f) axi.arvalid = 1'b0;
    end
    axi.arvalid = 1'b0; axi.rready = 1'b0;
  endtask

  task automatic test_reset();
    idle_master();
    reset = 1'b1;
    tick(); tick();
    total++; if (axi.arready !== 1'b0)
      $display("FAIL rst_arready got %b want 0", axi.arready);
      else pass_cnt++;
    total++; if (axi.awready !== 1'b0)
      $display("FAIL rst_awready got %b want 0", axi.awready);
      else pass_cnt++;
    total++; if (axi.wready !== 1'b0)
      $display("FAIL rst_wready got %b want 0", axi.wready);
      else pass_cnt++;
    total++; if (axi.rvalid !== 1'b0 || axi.bvalid !== 1'b0)
      $display("FAIL rst_valid got r%b b%b want 0", axi.rvalid, axi.bvalid);
      else pass_cnt++;
    total++; if (axi.rdata !== 32'h0 || axi.rlast !== 1'b0)
      $display("FAIL rst_rdata got %h/%b want 0", axi.rdata, axi.rlast);
      else pass_cnt++;
    total++; if (axi.rid !== 4'h0 || axi.bid !== 4'h0 ||
                 axi.rresp !== 2'b0 || axi.bresp !== 2'b0)
      $display("FAIL rst_ids got %h %h %b %b want 0", axi.rid, axi.bid,
               axi.rresp, axi.bresp);
      else pass_cnt++;
    reset = 1'b0;
    #1;
    total++; if ({axi.arready, axi.awready, axi.wready} !== 3'b111)
      $display("FAIL rst_release got %b want 111",
               {axi.arready, axi.awready, axi.wready});
      else pass_cnt++;
    tick();
  endtask

  task automatic test_read();
    logic [1:0] r;
    do_write(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 8'd0, r);
    total++; if (r !== 2'b00)
      $display("FAIL preload_bresp got %b want 00", r);
      else pass_cnt++;
    axi.araddr = 32'h8000_0002; axi.arlen = 8'd0; axi.arid = 4'hA;
    axi.arvalid = 1'b1; axi.rready = 1'b1;
    #1;
    total++; if (axi.arready !== 1'b1)
      $display("FAIL rd_arready got %b want 1", axi.arready);
      else pass_cnt++;
    tick();
    axi.arvalid = 1'b0;
    #1;
    total++; if (axi.rvalid !== 1'b0)
      $display("FAIL rd_early_rvalid got %b want 0", axi.rvalid);
      else pass_cnt++;
    tick();
    total++; if (axi.rvalid !== 1'b1)
      $display("FAIL rd_rvalid_t2 got %b want 1", axi.rvalid);
      else pass_cnt++;
    total++; if (axi.rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_rdata got %h want deadbeef", axi.rdata);
      else pass_cnt++;
    total++; if (axi.rresp !== 2'b00 || axi.rlast !== 1'b1)
      $display("FAIL rd_resp_last got %b/%b want 00/1", axi.rresp, axi.rlast);
      else pass_cnt++;
    total++; if (axi.rid !== 4'hA)
      $display("FAIL rd_rid got %h want a", axi.rid);
      else pass_cnt++;
    tick();
    total++; if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1)
      $display("FAIL rd_done got rv%b ar%b want 0/1", axi.rvalid, axi.arready);
      else pass_cnt++;
    axi.rready = 1'b0;
  endtask

  task automatic test_byte_write();
    logic [1:0]  r;
    logic [31:0] d;
    do_write(32'h8000_0004, 32'h1122_3344, 4'hF, 8'd0, r);
    do_write(32'h8000_0005, 32'h0000_AB00, 4'b0010, 8'd0, r);
    total++; if (r !== 2'b00)
      $display("FAIL bw_bresp got %b want 00", r);
      else pass_cnt++;
    do_read(32'h8000_0004, 8'd0, d, r);
    total++; if (d !== 32'h1122_AB44)
      $display("FAIL bw_readback got %h want 1122ab44", d);
      else pass_cnt++;
  endtask

  task automatic test_split_write();
    logic [1:0]  r;
    logic [31:0] d;
    axi.wdata = 32'h55AA_55AA; axi.wstrb = 4'hF; axi.wlast = 1'b1;
    axi.wvalid = 1'b1; axi.awvalid = 1'b0; axi.bready = 1'b1;
    #1;
    total++; if (axi.wready !== 1'b1)
      $display("FAIL sp_wready_t got %b want 1", axi.wready);
      else pass_cnt++;
    tick();
    axi.wvalid = 1'b0;
    #1;
    total++; if (axi.wready !== 1'b0 || axi.awready !== 1'b1)
      $display("FAIL sp_t1 got w%b aw%b want 0/1", axi.wready, axi.awready);
      else pass_cnt++;
    tick();
    total++; if (axi.awready !== 1'b1 || axi.wready !== 1'b0 ||
                 axi.bvalid !== 1'b0)
      $display("FAIL sp_t2 got aw%b w%b b%b want 1/0/0",
               axi.awready, axi.wready, axi.bvalid);
      else pass_cnt++;
    tick();
    axi.awaddr = 32'h8000_0008; axi.awlen = 8'd0; axi.awid = 4'h7;
    axi.awvalid = 1'b1;
    #1;
    total++; if (axi.awready !== 1'b1)
      $display("FAIL sp_t3_awready got %b want 1", axi.awready);
      else pass_cnt++;
    tick();
    axi.awvalid = 1'b0;
    #1;
    total++; if (axi.bvalid !== 1'b0 || axi.awready !== 1'b0)
      $display("FAIL sp_t4 got b%b aw%b want 0/0", axi.bvalid, axi.awready);
      else pass_cnt++;
    tick();
    total++; if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00)
      $display("FAIL sp_t5_bvalid got %b/%b want 1/00", axi.bvalid, axi.bresp);
      else pass_cnt++;
    total++; if (axi.bid !== 4'h7)
      $display("FAIL sp_bid got %h want 7", axi.bid);
      else pass_cnt++;
    tick();
    total++; if (axi.bvalid !== 1'b0 || axi.arready !== 1'b1)
      $display("FAIL sp_t6 got b%b ar%b want 0/1", axi.bvalid, axi.arready);
      else pass_cnt++;
    axi.bready = 1'b0;
    do_read(32'h8000_0008, 8'd0, d, r);
    total++; if (d !== 32'h55AA_55AA)
      $display("FAIL sp_readback got %h want 55aa55aa", d);
      else pass_cnt++;
  endtask

  task automatic test_backpressure();
    axi.araddr = 32'h8000_0004; axi.arlen = 8'd0; axi.arid = 4'h2;
    axi.arvalid = 1'b1; axi.rready = 1'b0;
    #1;
    tick();
    axi.arvalid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++; if (axi.rvalid !== 1'b1)
        $display("FAIL bp_rvalid[%0d] got %b want 1", k, axi.rvalid);
        else pass_cnt++;
      total++; if (axi.rdata !== 32'h1122_AB44)
        $display("FAIL bp_rdata[%0d] got %h want 1122ab44", k, axi.rdata);
        else pass_cnt++;
      total++; if (axi.arready !== 1'b0)
        $display("FAIL bp_arready[%0d] got %b want 0", k, axi.arready);
        else pass_cnt++;
      tick();
    end
    axi.rready = 1'b1;
    #1;
    total++; if (axi.rvalid !== 1'b1)
      $display("FAIL bp_final_rvalid got %b want 1", axi.rvalid);
      else pass_cnt++;
    tick();
    total++; if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1)
      $display("FAIL bp_done got rv%b ar%b want 0/1", axi.rvalid, axi.arready);
      else pass_cnt++;
    axi.rready = 1'b0;
  endtask

  task automatic test_errors();
    logic [1:0]  r;
    logic [31:0] d;
    do_read(32'h7FFF_FFFC, 8'd0, d, r);
    total++; if (r !== 2'b10)
      $display("FAIL err_rd_low got %b want 10", r);
      else pass_cnt++;
    do_read(32'h8000_0000, 8'd1, d, r);
    total++; if (r !== 2'b10)
      $display("FAIL err_rd_len got %b want 10", r);
      else pass_cnt++;
    do_write(32'h8000_0000, 32'h0, 4'hF, 8'd1, r);
    total++; if (r !== 2'b10)
      $display("FAIL err_wr_len got %b want 10", r);
      else pass_cnt++;
    do_write(32'h8000_4000, 32'h0, 4'hF, 8'd0, r);
    total++; if (r !== 2'b10)
      $display("FAIL err_wr_high got %b want 10", r);
      else pass_cnt++;
    do_write(32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 8'd0, r);
    total++; if (r !== 2'b00)
      $display("FAIL strb0_bresp got %b want 00", r);
      else pass_cnt++;
    do_read(32'h8000_0000, 8'd0, d, r);
    total++; if (d !== 32'hDEAD_BEEF || r !== 2'b00)
      $display("FAIL err_mem_intact got %h/%b want deadbeef/00", d, r);
      else pass_cnt++;
    do_write(32'h8000_3FFC, 32'h1234_5678, 4'hF, 8'd0, r);
    total++; if (r !== 2'b00)
      $display("FAIL top_word_bresp got %b want 00", r);
      else pass_cnt++;
    do_read(32'h8000_3FFC, 8'd0, d, r);
    total++; if (d !== 32'h1234_5678 || r !== 2'b00)
      $display("FAIL top_word_read got %h/%b want 12345678/00", d, r);
      else pass_cnt++;
  endtask

  task automatic test_priority();
    int          r_cyc, b_cyc;
    logic [31:0] rd, d;
    logic [1:0]  br, r;
    logic        ar_f, aw_f, w_f;
    axi.araddr = 32'h8000_0004; axi.arlen = 8'd0; axi.arid = 4'h6;
    axi.arvalid = 1'b1;
    axi.awaddr = 32'h8000_000C; axi.awlen = 8'd0; axi.awid = 4'h9;
    axi.awvalid = 1'b1;
    axi.wdata = 32'hCAFE_F00D; axi.wstrb = 4'hF; axi.wlast = 1'b1;
    axi.wvalid = 1'b1;
    axi.rready = 1'b1; axi.bready = 1'b1;
    #1;
    total++; if ({axi.arready, axi.awready, axi.wready} !== 3'b100)
      $display("FAIL prio_readies got %b want 100",
               {axi.arready, axi.awready, axi.wready});
      else pass_cnt++;
    r_cyc = -1; b_cyc = -1; rd = 'x; br = 2'bxx;
    for (int i = 0; i < 40 && b_cyc < 0; i++) begin
      #1;
      if (axi.rvalid && r_cyc < 0) begin
        r_cyc = i;
        rd = axi.rdata;
      end
      if (axi.bvalid) begin
        b_cyc = i;
        br = axi.bresp;
      end
      ar_f = axi.arvalid && axi.arready;
      aw_f = axi.awvalid && axi.awready;
      w_f  = axi.wvalid && axi.wready;
      tick();
      if (ar_f) axi.arvalid = 1'b0;
      if (aw_f) axi.awvalid = 1'b0;
      if (w_f) axi.wvalid = 1'b0;
    end
    idle_master();
    total++; if (rd !== 32'h1122_AB44)
      $display("FAIL prio_rdata got %h want 1122ab44", rd);
      else pass_cnt++;
    total++; if (r_cyc < 0 || b_cyc <= r_cyc)
      $display("FAIL prio_order got r@%0d b@%0d want r first", r_cyc, b_cyc);
      else pass_cnt++;
    total++; if (br !== 2'b00)
      $display("FAIL prio_bresp got %b want 00", br);
      else pass_cnt++;
    do_read(32'h8000_000C, 8'd0, d, r);
    total++; if (d !== 32'hCAFE_F00D)
      $display("FAIL prio_readback got %h want cafef00d", d);
      else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  r;
    logic        seen;
    axi.araddr = 32'h8000_0000; axi.arlen = 8'd0; axi.arid = 4'h1;
    axi.arvalid = 1'b1; axi.rready = 1'b1;
    #1;
    tick();
    axi.arvalid = 1'b0;
    reset = 1'b1;
    #1;
    total++; if (axi.arready !== 1'b0 || axi.rvalid !== 1'b0)
      $display("FAIL mid_rst got ar%b rv%b want 0/0", axi.arready, axi.rvalid);
      else pass_cnt++;
    seen = 1'b0;
    tick();
    seen = seen | axi.rvalid;
    tick();
    seen = seen | axi.rvalid;
    reset = 1'b0;
    #1;
    total++; if (axi.arready !== 1'b1)
      $display("FAIL mid_release_arready got %b want 1", axi.arready);
      else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      seen = seen | axi.rvalid;
      tick();
    end
    total++; if (seen !== 1'b0)
      $display("FAIL mid_rvalid_seen got %b want 0", seen);
      else pass_cnt++;
    axi.rready = 1'b0;
    do_read(32'h8000_0000, 8'd0, d, r);
    total++; if (d !== 32'hDEAD_BEEF)
      $display("FAIL mid_mem0 got %h want deadbeef", d);
      else pass_cnt++;
    do_read(32'h8000_0004, 8'd0, d, r);
    total++; if (d !== 32'h1122_AB44)
      $display("FAIL mid_mem1 got %h want 1122ab44", d);
      else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_byte_write();
    test_split_write();
    test_backpressure();
    test_errors();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
